// File: rtl/da_pkg.sv
// Shared types and constants for the DA waveform ROM reader.
// DA_ROM_READER_QUARTER_WAVE_EN narrows the ROM address port by two bits (quarter-wave table).
package da_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    // Legal ROM read latencies: unregistered and registered ROM outputs.
    localparam int ROM_LATENCY_COMB = 1;
    localparam int ROM_LATENCY_REG  = 2;

    function automatic int rom_port_width(input int addr_width);
`ifdef DA_ROM_READER_QUARTER_WAVE_EN
        return addr_width - 2;
`else
        return addr_width;
`endif
    endfunction

endpackage

// File: rtl/da_rom_reader_fifo.sv
// First-word-fall-through return buffer with occupancy count.
module da_rom_reader_fifo
    import da_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             valid,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count_q;
    logic             do_pop;

    assign do_pop = pop && (count_q != '0);
    assign valid  = (count_q != '0);
    assign head   = mem[rd_ptr];
    assign count  = count_q;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                wr_ptr <= ptr_next(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= ptr_next(rd_ptr);
            end
            case ({push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Credit accounting upstream must make a push into a full buffer impossible
    // unless the head is leaving in the same cycle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(push && !do_pop && (count_q == CNT_W'(DEPTH))));
        end
    end

endmodule

// File: rtl/da_rom_reader.sv
// DDS address generator and return-path collector for the DA waveform ROM.
// DA_ROM_READER_QUARTER_WAVE_EN selects quarter-wave folding of address and sample.
//
// state | meaning
// IDLE  | waiting for start; outputs quiet
// RUN   | issuing ROM reads whenever a buffer credit is free
// DRAIN | no new reads; waiting for in-flight reads and the buffer to empty
module da_rom_reader
    import da_pkg::*;
#(
    parameter int ADDR_WIDTH  = 10,
    parameter int DATA_WIDTH  = 8,
    parameter int PHASE_WIDTH = 32,
    parameter int ROM_LATENCY = 1,
    parameter int FIFO_DEPTH  = 4,
    localparam int ROM_AW = rom_port_width(ADDR_WIDTH)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   stop,
    input  logic [PHASE_WIDTH-1:0] freq_word,
    input  logic [ADDR_WIDTH-1:0]  phase_offset,
    output logic [ROM_AW-1:0]      rom_addr,
    output logic                   rom_addr_strobe,
    input  logic [DATA_WIDTH-1:0]  rom_rd_data,
    output logic [DATA_WIDTH-1:0]  dout,
    output logic                   dout_valid,
    input  logic                   dout_ready,
    output logic                   busy
);

    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam bit LAT_OK = (ROM_LATENCY == ROM_LATENCY_COMB) ||
                            (ROM_LATENCY == ROM_LATENCY_REG);

    state_t                  state;
    state_t                  state_nxt;
    logic [PHASE_WIDTH-1:0]  acc;
    logic [PHASE_WIDTH-1:0]  freq_q;
    logic [ADDR_WIDTH-1:0]   offset_q;
    logic [ROM_LATENCY-1:0]  vld_pipe;
    logic [CNT_W-1:0]        inflight;
    logic [CNT_W-1:0]        fifo_count;
    logic [CNT_W:0]          outstanding;
    logic                    credit_ok;
    logic                    issue;
    logic                    load;
    logic [ADDR_WIDTH-1:0]   full_addr;
    logic [ROM_AW-1:0]       issue_addr;
    logic [DATA_WIDTH-1:0]   ret_data;
    logic                    ret_valid;
    logic [DATA_WIDTH-1:0]   fifo_head;
    logic                    fifo_valid;
    logic                    pop;

    always_comb begin
        inflight = '0;
        for (int i = 0; i < ROM_LATENCY; i++) begin
            inflight = inflight + CNT_W'(vld_pipe[i]);
        end
    end

    // Registered counts only: a pop this cycle returns its credit next cycle.
    assign outstanding = {1'b0, fifo_count} + {1'b0, inflight};
    assign credit_ok   = (outstanding < (CNT_W + 1)'(FIFO_DEPTH));

    always_comb begin
        state_nxt = state;
        issue     = 1'b0;
        load      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = RUN;
                    load      = 1'b1;
                end
            end
            RUN: begin
                issue = credit_ok;
                if (stop) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if ((inflight == '0) && (fifo_count == '0)) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign full_addr = acc[PHASE_WIDTH-1 -: ADDR_WIDTH] + offset_q;

`ifdef DA_ROM_READER_QUARTER_WAVE_EN
    logic [1:0]             quad;
    logic [ROM_AW-1:0]      quad_idx;
    logic [ROM_LATENCY-1:0] inv_pipe;

    assign quad       = full_addr[ADDR_WIDTH-1 -: 2];
    assign quad_idx   = full_addr[ROM_AW-1:0];
    assign issue_addr = quad[0] ? ~quad_idx : quad_idx;
    // Offset-binary inversion: all-ones minus x equals bitwise ~x.
    assign ret_data   = inv_pipe[ROM_LATENCY-1] ? ~rom_rd_data : rom_rd_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inv_pipe <= '0;
        end else begin
            inv_pipe[0] <= issue & quad[1];
            for (int i = 1; i < ROM_LATENCY; i++) begin
                inv_pipe[i] <= inv_pipe[i-1];
            end
        end
    end
`else
    assign issue_addr = full_addr;
    assign ret_data   = rom_rd_data;
`endif

    assign rom_addr        = issue ? issue_addr : '0;
    assign rom_addr_strobe = issue;
    assign ret_valid       = vld_pipe[ROM_LATENCY-1];
    assign busy            = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            acc      <= '0;
            freq_q   <= '0;
            offset_q <= '0;
            vld_pipe <= '0;
        end else begin
            state <= state_nxt;
            if (load) begin
                freq_q   <= freq_word;
                offset_q <= phase_offset;
                acc      <= '0;
            end else if (issue) begin
                acc <= acc + freq_q;
            end
            vld_pipe[0] <= issue;
            for (int i = 1; i < ROM_LATENCY; i++) begin
                vld_pipe[i] <= vld_pipe[i-1];
            end
        end
    end

    assign pop = fifo_valid && dout_ready;

    da_rom_reader_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_WIDTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (ret_valid),
        .push_data (ret_data),
        .pop       (pop),
        .head      (fifo_head),
        .valid     (fifo_valid),
        .count     (fifo_count)
    );

    assign dout_valid = fifo_valid;
    assign dout       = fifo_valid ? fifo_head : '0;

    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (LAT_OK);
        end
    end

endmodule

// File: tb/tb_da_rom_reader.sv
// Bench for da_rom_reader: one instance per legal ROM latency, shared stimulus, reference model of the DDS sequence.
module tb_da_rom_reader;
    localparam int AW    = 10;
    localparam int DW    = 8;
    localparam int PW    = 32;
    localparam int DEPTH = 4;
    localparam int RAW   = da_pkg::rom_port_width(AW);

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic           stop;
    logic [PW-1:0]  freq_word;
    logic [AW-1:0]  phase_offset;
    logic           dout_ready;

    logic [RAW-1:0] rom_addr_s [2];
    logic           strb       [2];
    logic [DW-1:0]  rd_data    [2];
    logic [DW-1:0]  dout_s     [2];
    logic           dv         [2];
    logic           busy_s     [2];
    logic [DW-1:0]  rom1_stage;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // model state per instance
    bit            armed   [2];
    int            n_iss   [2];
    int            n_pop   [2];
    logic [PW-1:0] mfreq   [2];
    logic [AW-1:0] moff    [2];
    int            st_cyc  [2];
    int            first_s [2];
    int            first_v [2];
    bit            hold    [2];
    logic [DW-1:0] hold_d  [2];
    logic [31:0]   addr_log [2][16];
    logic [31:0]   dout_log [2][16];

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    da_rom_reader #(.ROM_LATENCY(1)) u_dut0 (
        .clk(clk), .rst(rst), .start(start), .stop(stop),
        .freq_word(freq_word), .phase_offset(phase_offset),
        .rom_addr(rom_addr_s[0]), .rom_addr_strobe(strb[0]), .rom_rd_data(rd_data[0]),
        .dout(dout_s[0]), .dout_valid(dv[0]), .dout_ready(dout_ready), .busy(busy_s[0])
    );

    da_rom_reader #(.ROM_LATENCY(2)) u_dut1 (
        .clk(clk), .rst(rst), .start(start), .stop(stop),
        .freq_word(freq_word), .phase_offset(phase_offset),
        .rom_addr(rom_addr_s[1]), .rom_addr_strobe(strb[1]), .rom_rd_data(rd_data[1]),
        .dout(dout_s[1]), .dout_valid(dv[1]), .dout_ready(dout_ready), .busy(busy_s[1])
    );

    function automatic logic [DW-1:0] rom_fn(input logic [RAW-1:0] a);
        int v;
        v = int'(a) * 7 + 3;
        return v[DW-1:0];
    endfunction

    always @(posedge clk) begin
        rd_data[0] <= rom_fn(rom_addr_s[0]);
        rom1_stage <= rom_fn(rom_addr_s[1]);
        rd_data[1] <= rom1_stage;
    end

    function automatic logic [AW-1:0] exp_full(input int n, input logic [PW-1:0] f, input logic [AW-1:0] o);
        logic [PW-1:0] ph;
        ph = PW'(n) * f;
        return ph[PW-1 -: AW] + o;
    endfunction

    function automatic logic [RAW-1:0] exp_rom_addr(input logic [AW-1:0] full);
`ifdef DA_ROM_READER_QUARTER_WAVE_EN
        logic [RAW-1:0] idx;
        idx = full[RAW-1:0];
        return full[AW-2] ? ~idx : idx;
`else
        return full;
`endif
    endfunction

    function automatic logic [DW-1:0] exp_sample(input logic [AW-1:0] full);
`ifdef DA_ROM_READER_QUARTER_WAVE_EN
        logic [DW-1:0] s;
        s = rom_fn(exp_rom_addr(full));
        return full[AW-1] ? (8'd255 - s) : s;
`else
        return rom_fn(full);
`endif
    endfunction

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endfunction

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                armed[i] = 1'b0;
                n_iss[i] = 0;
                n_pop[i] = 0;
                hold[i]  = 1'b0;
            end else begin
                if (start && !busy_s[i]) begin
                    armed[i]   = 1'b1;
                    mfreq[i]   = freq_word;
                    moff[i]    = phase_offset;
                    n_iss[i]   = 0;
                    n_pop[i]   = 0;
                    st_cyc[i]  = cyc;
                    first_s[i] = -1;
                    first_v[i] = -1;
                end
                if (!armed[i]) begin
                    chk($sformatf("quiet_strobe%0d", i), 32'(strb[i]), 0);
                    chk($sformatf("quiet_valid%0d", i), 32'(dv[i]), 0);
                end else begin
                    if (strb[i]) begin
                        chk($sformatf("addr%0d", i), 32'(rom_addr_s[i]),
                            32'(exp_rom_addr(exp_full(n_iss[i], mfreq[i], moff[i]))));
                        if (n_iss[i] < 16) addr_log[i][n_iss[i]] = 32'(rom_addr_s[i]);
                        if (first_s[i] < 0) first_s[i] = cyc;
                        n_iss[i]++;
                        chk($sformatf("credit%0d", i), 32'(n_iss[i] - n_pop[i] <= DEPTH), 1);
                    end
                    if (hold[i]) begin
                        chk($sformatf("hold_valid%0d", i), 32'(dv[i]), 1);
                        chk($sformatf("hold_data%0d", i), 32'(dout_s[i]), 32'(hold_d[i]));
                    end
                    if (dv[i]) begin
                        if (first_v[i] < 0) first_v[i] = cyc;
                        if (dout_ready) begin
                            chk($sformatf("beat_issued%0d", i), 32'(n_pop[i] < n_iss[i]), 1);
                            chk($sformatf("dout%0d", i), 32'(dout_s[i]),
                                32'(exp_sample(exp_full(n_pop[i], mfreq[i], moff[i]))));
                            if (n_pop[i] < 16) dout_log[i][n_pop[i]] = 32'(dout_s[i]);
                            n_pop[i]++;
                        end
                    end
                end
                hold[i]   = dv[i] && !dout_ready;
                hold_d[i] = dout_s[i];
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1;
        tick(1);
        stop = 1'b0;
    endtask

    task automatic wait_idle(input int limit);
        int n;
        n = 0;
        while ((busy_s[0] || busy_s[1]) && n < limit) begin
            tick(1);
            n++;
        end
        chk("drain_in_time", 32'(n < limit), 1);
        tick(2);
    endtask

    task automatic chk_quiet(input string tag);
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("%s_addr%0d", tag, i), 32'(rom_addr_s[i]), 0);
            chk($sformatf("%s_strobe%0d", tag, i), 32'(strb[i]), 0);
            chk($sformatf("%s_dout%0d", tag, i), 32'(dout_s[i]), 0);
            chk($sformatf("%s_valid%0d", tag, i), 32'(dv[i]), 0);
            chk($sformatf("%s_busy%0d", tag, i), 32'(busy_s[i]), 0);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    int pend [2];
    int pop_at_stop [2];
    int iss_at_stop [2];

    initial begin
        rst = 1'b1; start = 1'b0; stop = 1'b0;
        freq_word = '0; phase_offset = '0; dout_ready = 1'b1;
        tick(3);
        chk_quiet("reset");
        rst = 1'b0;
        tick(2);

        // sequential addresses, latency of first strobe and first sample
        freq_word = 32'h0040_0000; phase_offset = 10'd0; dout_ready = 1'b1;
        pulse_start();
        tick(12);
        pulse_stop();
        wait_idle(100);
        for (int k = 0; k < 4; k++) chk("seq_addr", addr_log[0][k], 32'(k));
        chk("seq_addr_l2", addr_log[1][3], 3);
        chk("seq_dout1", dout_log[0][1], 10);
        chk("seq_dout2_l2", dout_log[1][2], 17);
        chk("first_strobe_lat", 32'(first_s[0] - st_cyc[0]), 1);
        chk("first_valid_lat_l1", 32'(first_v[0] - st_cyc[0]), 3);
        chk("first_valid_lat_l2", 32'(first_v[1] - st_cyc[1]), 4);
        for (int i = 0; i < 2; i++) chk("seq_all_delivered", 32'(n_pop[i]), 32'(n_iss[i]));

        // address wrap through the offset
        phase_offset = 10'd1020;
        pulse_start();
        tick(8);
        pulse_stop();
        wait_idle(100);
`ifndef DA_ROM_READER_QUARTER_WAVE_EN
        chk("wrap_a0", addr_log[0][0], 1020);
        chk("wrap_a3", addr_log[0][3], 1023);
        chk("wrap_a4", addr_log[0][4], 0);
        chk("wrap_a5", addr_log[0][5], 1);
        chk("wrap_dout1", dout_log[0][1], 238);
`endif

        // backpressure: issues stop at the buffer depth
        freq_word = 32'h00C0_0000; phase_offset = 10'd0; dout_ready = 1'b0;
        pulse_start();
        tick(10);
        chk("bp_issued_l1", 32'(n_iss[0]), 4);
        chk("bp_issued_l2", 32'(n_iss[1]), 4);
        chk("bp_head_l2", 32'(dout_s[1]), 3);
        dout_ready = 1'b1;
        tick(10);
        pulse_stop();
        wait_idle(100);
        for (int i = 0; i < 2; i++) chk("bp_all_delivered", 32'(n_pop[i]), 32'(n_iss[i]));

        // fractional step, start ignored mid-run, drain count after stop
        freq_word = 32'h0018_0000;
        pulse_start();
        tick(4);
        freq_word = 32'h01C0_0000;
        pulse_start();
        tick(4);
        pulse_stop();
        for (int i = 0; i < 2; i++) begin
            pend[i] = n_iss[i] - n_pop[i];
            pop_at_stop[i] = n_pop[i];
            iss_at_stop[i] = n_iss[i];
        end
        chk("pending_l1", 32'(pend[0]), 2);
        chk("pending_l2", 32'(pend[1]), 3);
        wait_idle(100);
        for (int i = 0; i < 2; i++) begin
            chk("drain_beats", 32'(n_pop[i] - pop_at_stop[i]), 32'(pend[i]));
            chk("no_issue_after_stop", 32'(n_iss[i]), 32'(iss_at_stop[i]));
        end

        // stop in IDLE ignored; start wins over stop; freq_word=0 repeats one address
        pulse_stop();
        tick(1);
        chk("stop_idle_busy", 32'(busy_s[0]), 0);
        freq_word = '0; phase_offset = 10'd37;
        start = 1'b1; stop = 1'b1;
        tick(1);
        start = 1'b0; stop = 1'b0;
        chk("start_wins_l1", 32'(busy_s[0]), 1);
        chk("start_wins_l2", 32'(busy_s[1]), 1);
        tick(6);
`ifndef DA_ROM_READER_QUARTER_WAVE_EN
        chk("freq0_addr", addr_log[0][3], 37);
`endif
        pulse_stop();
        wait_idle(100);

        // reset with reads in flight
        freq_word = 32'h0040_0000; phase_offset = 10'd0; dout_ready = 1'b1;
        pulse_start();
        tick(5);
        rst = 1'b1;
        #1;
        chk_quiet("midrst");
        tick(2);
        rst = 1'b0;
        tick(6);
        for (int i = 0; i < 2; i++) begin
            chk("post_rst_valid", 32'(dv[i]), 0);
            chk("post_rst_busy", 32'(busy_s[i]), 0);
        end

`ifdef DA_ROM_READER_QUARTER_WAVE_EN
        // full period, one address per sample
        freq_word = 32'h0040_0000; phase_offset = 10'd0;
        pulse_start();
        tick(1030);
        pulse_stop();
        wait_idle(100);
        for (int i = 0; i < 2; i++) chk("qw_all_delivered", 32'(n_pop[i]), 32'(n_iss[i]));
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
